// File: rtl/icache_mshr_track.sv
// icache MSHR entry tracker: per-entry FREE/WAIT_REQ/WAIT_RSP/DONE state, round-robin
// memory request issue, refill tracking and lowest-index fill-done retirement.

module icache_mshr_track #(
    parameter int ENTRY_NUM = 8,
    parameter int IDX_W     = $clog2(ENTRY_NUM),
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ENTRY_NUM-1:0] v_free,
    input  logic                 alloc_vld,
    input  logic [IDX_W-1:0]     alloc_idx,
    input  logic [ADDR_W-1:0]    alloc_addr,
    output logic                 alloc_rdy,
    input  logic                 lookup_vld,
    input  logic [ADDR_W-1:0]    lookup_addr,
    output logic                 lookup_hit,
    output logic [IDX_W-1:0]     lookup_idx,
    output logic                 mem_req_vld,
    input  logic                 mem_req_rdy,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [IDX_W-1:0]     mem_req_id,
    input  logic                 mem_rsp_vld,
    input  logic [IDX_W-1:0]     mem_rsp_id,
    input  logic                 mem_rsp_last,
    output logic                 fill_done_vld,
    output logic [IDX_W-1:0]     fill_done_idx,
    output logic [ADDR_W-1:0]    fill_done_addr,
    input  logic                 fill_done_rdy,
    output logic                 rsp_err
);

    typedef enum logic [1:0] {ST_FREE, ST_WAIT_REQ, ST_WAIT_RSP, ST_DONE} state_e;

    logic [ENTRY_NUM-1:0][ADDR_W-1:0] line_addr;
    logic [ENTRY_NUM-1:0]             is_wreq, is_wrsp, is_done, hit_vec;
    logic [IDX_W-1:0]                 rr_ptr, rr_pick, fd_pick, lk_pick;
    logic                             req_hold, fd_hold;
    logic [IDX_W-1:0]                 req_hold_idx, fd_hold_idx;
    logic                             alloc_fire, req_fire, fd_fire;

    assign alloc_rdy  = v_free[alloc_idx];
    assign alloc_fire = alloc_vld & alloc_rdy;
    assign req_fire   = mem_req_vld & mem_req_rdy;
    assign fd_fire    = fill_done_vld & fill_done_rdy;

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
        state_e            state;
        logic [ADDR_W-1:0] addr_q;

        assign v_free[i]    = (state == ST_FREE);
        assign is_wreq[i]   = (state == ST_WAIT_REQ);
        assign is_wrsp[i]   = (state == ST_WAIT_RSP);
        assign is_done[i]   = (state == ST_DONE);
        assign line_addr[i] = addr_q;
        assign hit_vec[i]   = (state != ST_FREE) && (addr_q == lookup_addr);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_FREE;
            end else begin
                unique case (state)
                    ST_FREE:
                        if (alloc_fire && alloc_idx == IDX_W'(i)) state <= ST_WAIT_REQ;
                    ST_WAIT_REQ:
                        if (req_fire && mem_req_id == IDX_W'(i)) state <= ST_WAIT_RSP;
                    ST_WAIT_RSP:
                        if (mem_rsp_vld && mem_rsp_last && mem_rsp_id == IDX_W'(i))
                            state <= ST_DONE;
                    ST_DONE:
                        if (fd_fire && fill_done_idx == IDX_W'(i)) state <= ST_FREE;
                    default: state <= ST_FREE;
                endcase
            end
        end

        // Line address carries no reset; it is only meaningful while the entry is busy.
        always_ff @(posedge clk) begin
            if (alloc_fire && alloc_idx == IDX_W'(i)) addr_q <= alloc_addr;
        end
    end

    // First WAIT_REQ entry at or after the round-robin pointer.
    always_comb begin
        rr_pick = '0;
        for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
            if (is_wreq[rr_ptr + IDX_W'(k)]) rr_pick = rr_ptr + IDX_W'(k);
        end
    end

    always_comb begin
        fd_pick = '0;
        lk_pick = '0;
        for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
            if (is_done[k]) fd_pick = IDX_W'(k);
            if (hit_vec[k]) lk_pick = IDX_W'(k);
        end
    end

    assign mem_req_vld    = |is_wreq;
    assign mem_req_id     = req_hold ? req_hold_idx : rr_pick;
    assign mem_req_addr   = line_addr[mem_req_id];

    assign fill_done_vld  = |is_done;
    assign fill_done_idx  = fd_hold ? fd_hold_idx : fd_pick;
    assign fill_done_addr = line_addr[fill_done_idx];

    assign lookup_hit     = lookup_vld & (|hit_vec);
    assign lookup_idx     = lk_pick;

    // A stalled offer is pinned so a newly eligible entry cannot displace it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            req_hold     <= 1'b0;
            req_hold_idx <= '0;
            fd_hold      <= 1'b0;
            fd_hold_idx  <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (req_fire) rr_ptr <= mem_req_id + IDX_W'(1);
            req_hold     <= mem_req_vld & ~mem_req_rdy;
            req_hold_idx <= mem_req_id;
            fd_hold      <= fill_done_vld & ~fill_done_rdy;
            fd_hold_idx  <= fill_done_idx;
            if (mem_rsp_vld && !is_wrsp[mem_rsp_id]) rsp_err <= 1'b1;
        end
    end

endmodule

// File: doc/icache_mshr_track.md
Name: icache_mshr_track

Overview:
Per-entry state tracker for the icache miss-status holding registers. It publishes the free-entry vector consumed by the MSHR pre-allocation stage. It accepts the allocated index plus miss line address, and issues one memory read per entry. It tracks refill responses and retires entries through a fill-done handshake back to the icache refill path.

Parameters:
ENTRY_NUM, 8, number of MSHR entries (power of two, >=2)
IDX_W, $clog2(ENTRY_NUM), entry index / transaction id width
ADDR_W, 32, cache-line address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
v_free  out  ENTRY_NUM  bit i=1 when entry i is FREE (registered state decode)
alloc_vld  in  1  allocation request
alloc_idx  in  IDX_W  entry chosen by pre-allocator
alloc_addr  in  ADDR_W  miss line address
alloc_rdy  out  1  =v_free[alloc_idx]
lookup_vld  in  1  duplicate-miss probe
lookup_addr  in  ADDR_W  probe address
lookup_hit  out  1  probe matches a non-FREE entry (combinational)
lookup_idx  out  IDX_W  lowest matching entry index
mem_req_vld  out  1  memory read request valid
mem_req_rdy  in  1  memory accepts request
mem_req_addr  out  ADDR_W  request line address
mem_req_id  out  IDX_W  entry index used as transaction id
mem_rsp_vld  in  1  refill beat valid
mem_rsp_id  in  IDX_W  transaction id of beat
mem_rsp_last  in  1  final beat of refill
fill_done_vld  out  1  entry refill complete
fill_done_idx  out  IDX_W  completed entry
fill_done_addr  out  ADDR_W  completed line address
fill_done_rdy  in  1  consumer accepts completion
rsp_err  out  1  sticky: beat received for entry not in WAIT_RSP

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All entries go FREE and v_free is all ones. mem_req_vld, fill_done_vld and rsp_err are 0. Address registers are don't-care. Reset mid-transaction drops all state; late responses after reset set rsp_err.
- Per-entry FSM: FREE -> WAIT_REQ -> WAIT_RSP -> DONE -> FREE.
  - FREE->WAIT_REQ when alloc_vld & alloc_rdy; alloc_addr is latched.
  - WAIT_REQ->WAIT_RSP when that entry wins the request arbiter and mem_req_rdy=1.
  - WAIT_RSP->DONE when mem_rsp_vld & mem_rsp_id==i & mem_rsp_last. Non-last beats cause no state change.
  - DONE->FREE when it is the selected fill-done entry and fill_done_rdy=1.
- All transitions are registered. Allocation in cycle N gives mem_req_vld no earlier than N+1.
  - A freed entry shows v_free=1 in the cycle after the handshake.
  - An entry cannot be freed and reallocated in the same cycle.
- alloc_vld with alloc_rdy=0 is ignored, and no state changes.
- Request arbiter: round-robin over WAIT_REQ entries.
  - The pointer advances to winner+1 (mod ENTRY_NUM) only on mem_req_vld & mem_req_rdy.
  - mem_req_vld, addr and id are combinational from registered state. They stay stable while mem_req_rdy=0, unless a higher-priority entry becomes WAIT_REQ only when no request is pending. Implement this by holding the winner registered while vld & !rdy.
- Fill-done select: fixed priority, lowest-index DONE entry. fill_done_* stay stable while fill_done_rdy=0.
- mem_rsp for an entry not in WAIT_RSP: beat is ignored and rsp_err is set to 1 until reset.
- Same-cycle events on different entries (alloc, req accept, rsp last, fill done) all take effect independently.
- Lookup compares lookup_addr against all non-FREE entries. When lookup_vld=0, lookup_hit=0. An entry allocated in the current cycle is not matched until the next cycle.

Test Plan:
- Reset then idle -> v_free=8'hFF, mem_req_vld=0, fill_done_vld=0, rsp_err=0.
- Alloc idx 3 addr 0x1000, mem_req_rdy=1 -> next cycle mem_req_vld=1, id=3, addr=0x1000. Response id 3 with last=1 -> fill_done_vld=1, idx=3. Accept -> v_free[3]=1 one cycle later.
- Alloc entries 0,1,2 back-to-back, mem_req_rdy held 0 for 5 cycles -> request stays id=0, stable. Release -> ids issued 0,1,2 in order. Round-robin pointer ends at 3.
- Entries 2 and 5 both DONE, fill_done_rdy=1 -> idx 2 retires then idx 5. Meanwhile alloc to idx 2 is refused (alloc_rdy=0) until the cycle after its retire.
- Response id 6 while entry 6 FREE -> rsp_err=1 sticky, no state change. Multi-beat response (3 beats, last on 3rd) -> DONE only after third beat.
- Lookup 0x2000 while entry 4 holds 0x2000 in WAIT_RSP -> lookup_hit=1, lookup_idx=4. After entry 4 retires -> lookup_hit=0.
